// File: rtl/if_stage_pkg.sv
// Shared definitions for the S_c instruction-fetch stage: reset values,
// PC increment and the next-PC source encoding.
package if_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_BR  = 2'd1,
    PC_J   = 2'd2,
    PC_JR  = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/if_stage_if.sv
// Bundle of hazard, redirect, instruction-memory and IF/ID signals seen by the fetch stage.
// master is the fetch stage itself; slave is the surrounding datapath.
interface if_stage_if;

  logic        stall;
  logic        flush;
  logic        br_taken;
  logic [31:0] br_imm;
  logic        j_taken;
  logic [25:0] j_index;
  logic        jr_taken;
  logic [31:0] jr_addr;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic [31:0] fetch_cnt;

  modport master (
    input  stall, flush, br_taken, br_imm, j_taken, j_index, jr_taken, jr_addr, im_instr,
    output im_addr, id_instr, id_pc4, id_valid, fetch_cnt
  );

  modport slave (
    output stall, flush, br_taken, br_imm, j_taken, j_index, jr_taken, jr_addr, im_instr,
    input  im_addr, id_instr, id_pc4, id_valid, fetch_cnt
  );

endinterface

// File: rtl/if_stage_pc_next_sel.sv
// Next-PC selection: priority encode of the (already qualified) redirect
// requests, jr > j > br > sequential, plus the target arithmetic.
module pc_next_sel
  import if_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] id_pc4,
  input  logic        br_req,
  input  logic [31:0] br_imm,
  input  logic        j_req,
  input  logic [25:0] j_index,
  input  logic        jr_req,
  input  logic [31:0] jr_addr,
  output logic [31:0] next_pc,
  output pc_sel_e     pc_sel
);

  logic [31:0] seq_target_s;
  logic [31:0] br_target_s;
  logic [31:0] j_target_s;
  logic [31:0] jr_target_s;

  // Word offsets scale by 4; the top two immediate bits fall off the 32-bit shift.
  assign seq_target_s = pc + PC_INC;
  assign br_target_s  = id_pc4 + (br_imm << 2);
  assign j_target_s   = {id_pc4[31:28], j_index, 2'b00};
  assign jr_target_s  = jr_addr & 32'hFFFF_FFFC;

  // Source priority encode
  always_comb begin
    pc_sel = PC_SEQ;
    if (jr_req) begin
      pc_sel = PC_JR;
    end else if (j_req) begin
      pc_sel = PC_J;
    end else if (br_req) begin
      pc_sel = PC_BR;
    end else begin
      pc_sel = PC_SEQ;
    end
  end

  // Target mux
  always_comb begin
    next_pc = seq_target_s;
    case (pc_sel)
      PC_SEQ:  next_pc = seq_target_s;
      PC_BR:   next_pc = br_target_s;
      PC_J:    next_pc = j_target_s;
      PC_JR:   next_pc = jr_target_s;
      default: next_pc = seq_target_s;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and fetch counter.
// No delay slot: a redirect squashes the word fetched in the same cycle.
module if_stage
  import if_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  if_stage_if.master bus
);

  logic [31:0] pc_r;
  logic [31:0] id_instr_r;
  logic [31:0] id_pc4_r;
  logic        id_valid_r;
  logic [31:0] fetch_cnt_r;

  logic [31:0] next_pc_s;
  pc_sel_e     pc_sel_s;
  logic        br_req_s;
  logic        j_req_s;
  logic        jr_req_s;
  logic        redirect_s;
  logic        bubble_s;

  // A redirect only belongs to a real instruction sitting in IF/ID.
  assign br_req_s = bus.br_taken & id_valid_r;
  assign j_req_s  = bus.j_taken  & id_valid_r;
  assign jr_req_s = bus.jr_taken & id_valid_r;

  pc_next_sel u_pc_next_sel (
    .pc      (pc_r),
    .id_pc4  (id_pc4_r),
    .br_req  (br_req_s),
    .br_imm  (bus.br_imm),
    .j_req   (j_req_s),
    .j_index (bus.j_index),
    .jr_req  (jr_req_s),
    .jr_addr (bus.jr_addr),
    .next_pc (next_pc_s),
    .pc_sel  (pc_sel_s)
  );

  // Squash decision for the word fetched this cycle
  always_comb begin
    redirect_s = 1'b0;
    bubble_s   = 1'b0;
    if (pc_sel_s != PC_SEQ) begin
      redirect_s = 1'b1;
    end else begin
      redirect_s = 1'b0;
    end
    bubble_s = redirect_s | bus.flush;
  end

  // PC, IF/ID and fetch counter; stall holds everything and drops pending requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r        <= RESET_PC;
      id_instr_r  <= NOP_WORD;
      id_pc4_r    <= 32'h0000_0000;
      id_valid_r  <= 1'b0;
      fetch_cnt_r <= 32'h0000_0000;
    end else if (!bus.stall) begin
      pc_r <= next_pc_s;
      if (bubble_s) begin
        id_instr_r <= NOP_WORD;
        id_pc4_r   <= 32'h0000_0000;
        id_valid_r <= 1'b0;
      end else begin
        id_instr_r  <= bus.im_instr;
        id_pc4_r    <= pc_r + PC_INC;
        id_valid_r  <= 1'b1;
        fetch_cnt_r <= fetch_cnt_r + 32'd1;
      end
    end
  end

  assign bus.im_addr   = pc_r;
  assign bus.id_instr  = id_instr_r;
  assign bus.id_pc4    = id_pc4_r;
  assign bus.id_valid  = id_valid_r;
  assign bus.fetch_cnt = fetch_cnt_r;

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage with a combinational instruction
// memory model; multi-cycle reset corner cases are hand-sequenced at the end.
module tb_if_stage;
  import if_pkg::*;

  logic clk;
  logic rst_n;

  if_stage_if bus ();

  if_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: every address returns a distinct word.
  function automatic logic [31:0] mw(input logic [31:0] a);
    return 32'hAB00_0000 ^ a;
  endfunction

  assign bus.im_instr = mw(bus.im_addr);

  typedef struct {
    logic        stall;
    logic        flush;
    logic        br;
    logic [31:0] br_imm;
    logic        j;
    logic [25:0] j_index;
    logic        jr;
    logic [31:0] jr_addr;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  function automatic void add(input logic st, input logic fl, input logic br,
                              input logic [31:0] bimm, input logic j, input logic [25:0] jidx,
                              input logic jr, input logic [31:0] jra,
                              input logic [31:0] pc, input logic [31:0] ins,
                              input logic [31:0] pc4, input logic v, input logic [31:0] cnt);
    vec_t t;
    t.stall = st; t.flush = fl; t.br = br; t.br_imm = bimm; t.j = j; t.j_index = jidx;
    t.jr = jr; t.jr_addr = jra; t.e_pc = pc; t.e_instr = ins; t.e_pc4 = pc4;
    t.e_valid = v; t.e_cnt = cnt;
    vecs.push_back(t);
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endfunction

  function automatic void chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                                  input logic [31:0] pc4, input logic v, input logic [31:0] cnt);
    chk({tag, " im_addr"},   bus.im_addr,          pc);
    chk({tag, " id_instr"},  bus.id_instr,         ins);
    chk({tag, " id_pc4"},    bus.id_pc4,           pc4);
    chk({tag, " id_valid"},  {31'd0, bus.id_valid}, {31'd0, v});
    chk({tag, " fetch_cnt"}, bus.fetch_cnt,        cnt);
  endfunction

  task automatic drive_idle();
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.br_taken = 1'b0; bus.br_imm = 32'd0;
    bus.j_taken = 1'b0; bus.j_index = 26'd0;
    bus.jr_taken = 1'b0; bus.jr_addr = 32'd0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive_idle();
    rst_n = 1'b1;

    //  st    fl    br    br_imm        j     j_index       jr    jr_addr        pc             instr               pc4            v     cnt
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 26'h0,        1'b0, 32'h0,         32'h0000_0004, mw(32'h0000_0000),  32'h0000_0004, 1'b1, 32'd1);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 26'h0,        1'b0, 32'h0,         32'h0000_0008, mw(32'h0000_0004),  32'h0000_0008, 1'b1, 32'd2);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 26'h0,        1'b0, 32'h0,         32'h0000_000C, mw(32'h0000_0008),  32'h0000_000C, 1'b1, 32'd3);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 26'h0,        1'b0, 32'h0,         32'h0000_0010, mw(32'h0000_000C),  32'h0000_0010, 1'b1, 32'd4);
    // Backward branch at id_pc4 = 0x10 to 0x08, then one bubble
    add(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE,1'b0, 26'h0,        1'b0, 32'h0,         32'h0000_0008, NOP_WORD,           32'h0000_0000, 1'b0, 32'd4);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 26'h0,        1'b0, 32'h0,         32'h0000_000C, mw(32'h0000_0008),  32'h0000_000C, 1'b1, 32'd5);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 26'h0,        1'b0, 32'h0,         32'h0000_0010, mw(32'h0000_000C),  32'h0000_0010, 1'b1, 32'd6);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 26'h0,        1'b0, 32'h0,         32'h0000_0014, mw(32'h0000_0010),  32'h0000_0014, 1'b1, 32'd7);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 26'h0,        1'b0, 32'h0,         32'h0000_0018, mw(32'h0000_0014),  32'h0000_0018, 1'b1, 32'd8);
    // Flush: bubble, PC still advances by 4
    add(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 26'h0,        1'b0, 32'h0,         32'h0000_001C, NOP_WORD,           32'h0000_0000, 1'b0, 32'd8);
    // Branch while id_valid=0 is ignored
    add(1'b0, 1'b0, 1'b1, 32'h0000_0100,1'b0, 26'h0,        1'b0, 32'h0,         32'h0000_0020, mw(32'h0000_001C),  32'h0000_0020, 1'b1, 32'd9);
    // Flush under stall, then 3 stalled branch cycles: all hold
    add(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 26'h0,        1'b0, 32'h0,         32'h0000_0020, mw(32'h0000_001C),  32'h0000_0020, 1'b1, 32'd9);
    add(1'b1, 1'b0, 1'b1, 32'h0000_0004,1'b0, 26'h0,        1'b0, 32'h0,         32'h0000_0020, mw(32'h0000_001C),  32'h0000_0020, 1'b1, 32'd9);
    add(1'b1, 1'b0, 1'b1, 32'h0000_0004,1'b0, 26'h0,        1'b0, 32'h0,         32'h0000_0020, mw(32'h0000_001C),  32'h0000_0020, 1'b1, 32'd9);
    add(1'b1, 1'b0, 1'b1, 32'h0000_0004,1'b0, 26'h0,        1'b0, 32'h0,         32'h0000_0020, mw(32'h0000_001C),  32'h0000_0020, 1'b1, 32'd9);
    // Released: branch honored once (0x20 + 16), re-assertion on the bubble ignored
    add(1'b0, 1'b0, 1'b1, 32'h0000_0004,1'b0, 26'h0,        1'b0, 32'h0,         32'h0000_0030, NOP_WORD,           32'h0000_0000, 1'b0, 32'd9);
    add(1'b0, 1'b0, 1'b1, 32'h0000_0004,1'b0, 26'h0,        1'b0, 32'h0,         32'h0000_0034, mw(32'h0000_0030),  32'h0000_0034, 1'b1, 32'd10);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 26'h0,        1'b1, 32'h1000_0000, 32'h1000_0000, NOP_WORD,           32'h0000_0000, 1'b0, 32'd10);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 26'h0,        1'b0, 32'h0,         32'h1000_0004, mw(32'h1000_0000),  32'h1000_0004, 1'b1, 32'd11);
    // jr + j + br together: jr wins with low bits cleared
    add(1'b0, 1'b0, 1'b1, 32'h0000_0010,1'b1, 26'h40,       1'b1, 32'h0000_0203, 32'h0000_0200, NOP_WORD,           32'h0000_0000, 1'b0, 32'd11);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 26'h0,        1'b0, 32'h0,         32'h0000_0204, mw(32'h0000_0200),  32'h0000_0204, 1'b1, 32'd12);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 26'h40,       1'b0, 32'h0,         32'h0000_0100, NOP_WORD,           32'h0000_0000, 1'b0, 32'd12);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 26'h0,        1'b0, 32'h0,         32'h0000_0104, mw(32'h0000_0100),  32'h0000_0104, 1'b1, 32'd13);
    // j beats br
    add(1'b0, 1'b0, 1'b1, 32'h0000_0008,1'b1, 26'h3FF_FFFF, 1'b0, 32'h0,         32'h0FFF_FFFC, NOP_WORD,           32'h0000_0000, 1'b0, 32'd13);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 26'h0,        1'b0, 32'h0,         32'h1000_0000, mw(32'h0FFF_FFFC),  32'h1000_0000, 1'b1, 32'd14);
    // Jump keeps id_pc4[31:28]
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 26'h1,        1'b0, 32'h0,         32'h1000_0004, NOP_WORD,           32'h0000_0000, 1'b0, 32'd14);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 26'h0,        1'b0, 32'h0,         32'h1000_0008, mw(32'h1000_0004),  32'h1000_0008, 1'b1, 32'd15);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 26'h0,        1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, NOP_WORD,           32'h0000_0000, 1'b0, 32'd15);
    // Sequential wrap 0xFFFF_FFFC -> 0
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 26'h0,        1'b0, 32'h0,         32'h0000_0000, mw(32'hFFFF_FFFC),  32'h0000_0000, 1'b1, 32'd16);
    // Branch target wraps below zero
    add(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF,1'b0, 26'h0,        1'b0, 32'h0,         32'hFFFF_FFFC, NOP_WORD,           32'h0000_0000, 1'b0, 32'd16);

    // Async reset applied between edges takes effect at once
    #2 rst_n = 1'b0;
    #1 chk_all("reset", RESET_PC, NOP_WORD, 32'h0, 1'b0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.stall    = vecs[i].stall;
      bus.flush    = vecs[i].flush;
      bus.br_taken = vecs[i].br;
      bus.br_imm   = vecs[i].br_imm;
      bus.j_taken  = vecs[i].j;
      bus.j_index  = vecs[i].j_index;
      bus.jr_taken = vecs[i].jr;
      bus.jr_addr  = vecs[i].jr_addr;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pc4,
              vecs[i].e_valid, vecs[i].e_cnt);
    end

    // Run sequentially from 0xFFFF_FFFC up to pc = 0x40
    drive_idle();
    for (int k = 0; k < 17; k++) begin
      @(posedge clk);
    end
    #1 chk_all("run_to_40", 32'h0000_0040, mw(32'h0000_003C), 32'h0000_0040, 1'b1, 32'd33);

    // Reset mid-stall with a pending branch: everything cleared immediately
    bus.stall    = 1'b1;
    bus.br_taken = 1'b1;
    bus.br_imm   = 32'h0000_0010;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all("reset_mid", RESET_PC, NOP_WORD, 32'h0, 1'b0, 32'd0);
    @(posedge clk);
    #1 chk_all("reset_hold", RESET_PC, NOP_WORD, 32'h0, 1'b0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle();
    @(posedge clk);
    #1 chk_all("first_fetch", RESET_PC + 32'd4, mw(RESET_PC), RESET_PC + 32'd4, 1'b1, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
